// File: rtl/multicycle_control_if.sv
// multicycle_control_if: instruction/data handshake and datapath control bundle
// between the LEGv8 multi-cycle control unit (master) and the datapath (slave).
interface multicycle_control_if #(
    parameter int ALUOP_W  = 4,
    parameter int SIGNOP_W = 3
);
    logic [10:0]         opcode;
    logic                zero;
    logic                mem_ready;
    logic                instr_req;
    logic                ir_write;
    logic                mem_read;
    logic                mem_write;
    logic                reg_write;
    logic                pc_write;
    logic                pc_src;
    logic                reg2loc;
    logic                alusrc;
    logic                mem2reg;
    logic                move;
    logic [ALUOP_W-1:0]  aluop;
    logic [SIGNOP_W-1:0] signop;
    logic [2:0]          state;
    logic                illegal;
    logic                timeout;

    modport master (
        input  opcode, zero, mem_ready,
        output instr_req, ir_write, mem_read, mem_write, reg_write, pc_write, pc_src,
               reg2loc, alusrc, mem2reg, move, aluop, signop, state, illegal, timeout
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  instr_req, ir_write, mem_read, mem_write, reg_write, pc_write, pc_src,
               reg2loc, alusrc, mem2reg, move, aluop, signop, state, illegal, timeout
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing LEGv8 instructions through fetch/decode/execute/
// memory/writeback with a ready handshake, illegal-opcode trap and memory timeout trap.
module multicycle_control #(
    parameter int MAX_WAIT = 15,
    parameter int ALUOP_W  = 4,
    parameter int SIGNOP_W = 3
) (
    input logic                  CLK,
    input logic                  Reset_L,
    multicycle_control_if.master bus
);
    localparam int CW = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1;

    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP} state_t;
    typedef enum logic [3:0] {
        C_NONE, C_LDUR, C_STUR, C_ADD, C_SUB, C_ADDI, C_SUBI, C_AND, C_ORR, C_CBZ, C_B, C_MOVZ
    } cls_t;

    state_t         st, nxt;
    cls_t           cls, dec;
    logic [CW-1:0]  cnt;
    logic           ill, tmo, wait_st, to, act;
    logic [3:0]     aluop4;
    logic [2:0]     signop3;

    always_comb begin
        casez (bus.opcode)
            11'b??111000010: dec = C_LDUR;
            11'b??111000000: dec = C_STUR;
            11'b?0?01011???: dec = C_ADD;
            11'b?1?01011???: dec = C_SUB;
            11'b?0?10001???: dec = C_ADDI;
            11'b?1?10001???: dec = C_SUBI;
            11'b?0001010???: dec = C_AND;
            11'b?0101010???: dec = C_ORR;
            11'b?011010????: dec = C_CBZ;
            11'b?00101?????: dec = C_B;
            11'b110100101??: dec = C_MOVZ;
            default:         dec = C_NONE;
        endcase
    end

    // Ready in the limit cycle beats the timeout because to requires mem_ready low.
    assign wait_st = st == FETCH || st == MEMORY;
    assign to      = MAX_WAIT > 0 && wait_st && !bus.mem_ready && cnt == CW'(MAX_WAIT);

    always_comb begin
        case (st)
            FETCH:     nxt = bus.mem_ready ? DECODE : (to ? TRAP : FETCH);
            DECODE:    nxt = dec == C_NONE ? TRAP : EXECUTE;
            EXECUTE:   nxt = (cls == C_B || cls == C_CBZ) ? FETCH :
                             (cls == C_LDUR || cls == C_STUR) ? MEMORY : WRITEBACK;
            MEMORY:    nxt = bus.mem_ready ? (cls == C_LDUR ? WRITEBACK : FETCH) : (to ? TRAP : MEMORY);
            WRITEBACK: nxt = FETCH;
            default:   nxt = TRAP;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            st  <= FETCH;
            cnt <= '0;
            cls <= C_NONE;
            ill <= 1'b0;
            tmo <= 1'b0;
        end else begin
            st  <= nxt;
            cnt <= (nxt != st || !wait_st) ? '0 : cnt + CW'(1);
            if (st == DECODE && dec != C_NONE) cls <= dec;
            if (st == DECODE && dec == C_NONE) ill <= 1'b1;
            if (to) tmo <= 1'b1;
        end
    end

    // Mux selects only reflect the latched word while an instruction is executing.
    assign act = st == EXECUTE || st == MEMORY || st == WRITEBACK;

    always_comb begin
        aluop4  = !act ? 4'b0000 :
                  cls inside {C_ADD, C_LDUR, C_STUR, C_ADDI} ? 4'b0010 :
                  cls inside {C_SUB, C_SUBI} ? 4'b0110 :
                  cls == C_ORR ? 4'b0001 :
                  cls == C_CBZ ? 4'b0111 : 4'b0000;
        signop3 = !act ? 3'b000 :
                  cls inside {C_LDUR, C_STUR} ? 3'b010 :
                  cls == C_B ? 3'b001 :
                  cls == C_CBZ ? 3'b011 :
                  cls == C_MOVZ ? 3'b100 : 3'b000;
    end

    assign bus.instr_req = st == FETCH && Reset_L && !to;
    assign bus.ir_write  = st == FETCH && Reset_L && bus.mem_ready;
    assign bus.mem_read  = st == MEMORY && cls == C_LDUR && !to;
    assign bus.mem_write = st == MEMORY && cls == C_STUR && !to;
    assign bus.reg_write = st == WRITEBACK;
    assign bus.pc_write  = st == WRITEBACK || (st == EXECUTE && (cls == C_B || cls == C_CBZ)) ||
                           (st == MEMORY && cls == C_STUR && bus.mem_ready);
    assign bus.pc_src    = st == EXECUTE && (cls == C_B || (cls == C_CBZ && bus.zero));
    assign bus.reg2loc   = act && (cls == C_STUR || cls == C_CBZ);
    assign bus.alusrc    = act && (cls == C_LDUR || cls == C_STUR);
    assign bus.mem2reg   = act && cls == C_LDUR;
    assign bus.move      = act && cls == C_MOVZ;
    assign bus.aluop     = ALUOP_W'(aluop4);
    assign bus.signop    = SIGNOP_W'(signop3);
    assign bus.state     = st;
    assign bus.illegal   = ill;
    assign bus.timeout   = tmo;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench; each scenario queues per-cycle stimulus with the
// expected state/strobes/control word, and drain replays it one cycle at a time.
module tb_multicycle_control;
    logic CLK = 1'b0;
    logic Reset_L = 1'b1;
    always #5 CLK = ~CLK;

    multicycle_control_if #(.ALUOP_W(4), .SIGNOP_W(3)) bus();
    multicycle_control #(.MAX_WAIT(4), .ALUOP_W(4), .SIGNOP_W(3)) dut (
        .CLK(CLK), .Reset_L(Reset_L), .bus(bus)
    );

    typedef struct {
        logic        rdy;
        logic [10:0] op;
        logic        z;
        logic [2:0]  st;
        logic [6:0]  s;
        logic [10:0] m;
        logic [1:0]  f;
    } cyc_t;

    cyc_t q[$];
    int passed = 0;
    int total = 0;
    int pulses = 0;

    // m = {reg2loc, alusrc, mem2reg, move, aluop, signop}
    localparam logic [10:0] M_ADD  = {4'b0000, 4'b0010, 3'b000};
    localparam logic [10:0] M_SUB  = {4'b0000, 4'b0110, 3'b000};
    localparam logic [10:0] M_AND  = {4'b0000, 4'b0000, 3'b000};
    localparam logic [10:0] M_ORR  = {4'b0000, 4'b0001, 3'b000};
    localparam logic [10:0] M_MOVZ = {4'b0001, 4'b0000, 3'b100};
    localparam logic [10:0] M_LDUR = {4'b0110, 4'b0010, 3'b010};
    localparam logic [10:0] M_STUR = {4'b1100, 4'b0010, 3'b010};
    localparam logic [10:0] M_CBZ  = {4'b1000, 4'b0111, 3'b011};
    localparam logic [10:0] M_B    = {4'b0000, 4'b0000, 3'b001};
    // s = {instr_req, ir_write, mem_read, mem_write, reg_write, pc_write, pc_src}
    localparam logic [6:0] S_FW  = 7'b1000000;
    localparam logic [6:0] S_FR  = 7'b1100000;
    localparam logic [6:0] S_RD  = 7'b0010000;
    localparam logic [6:0] S_WR  = 7'b0001000;
    localparam logic [6:0] S_WRD = 7'b0001010;
    localparam logic [6:0] S_WB  = 7'b0000110;

    function automatic logic [10:0] rop();
        return 11'($urandom);
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    task automatic push(input logic rdy, input logic [10:0] op, input logic z, input logic [2:0] st,
                        input logic [6:0] s, input logic [10:0] m, input logic [1:0] f);
        cyc_t c;
        c.rdy = rdy; c.op = op; c.z = z; c.st = st; c.s = s; c.m = m; c.f = f;
        q.push_back(c);
    endtask

    // kind: 0 branch, 1 writeback class, 2 LDUR, 3 STUR
    task automatic run_instr(input logic [10:0] op, input logic z, input int fw, input int mw,
                             input int kind, input logic psrc, input logic [10:0] m);
        for (int i = 0; i < fw; i++) push(1'b0, rop(), rbit(), 3'd0, S_FW, 11'd0, 2'b00);
        push(1'b1, rop(), rbit(), 3'd0, S_FR, 11'd0, 2'b00);
        push(1'b1, op, rbit(), 3'd1, 7'd0, 11'd0, 2'b00);
        push(1'b1, rop(), kind == 0 ? z : rbit(), 3'd2, kind == 0 ? {6'b000001, psrc} : 7'd0, m, 2'b00);
        if (kind >= 2) begin
            for (int i = 0; i < mw; i++) push(1'b0, rop(), rbit(), 3'd3, kind == 2 ? S_RD : S_WR, m, 2'b00);
            push(1'b1, rop(), rbit(), 3'd3, kind == 2 ? S_RD : S_WRD, m, 2'b00);
        end
        if (kind == 1 || kind == 2) push(1'b1, rop(), rbit(), 3'd4, S_WB, m, 2'b00);
    endtask

    task automatic drain(input string nm);
        cyc_t c;
        logic [22:0] got, exp;
        int n = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            bus.mem_ready = c.rdy;
            bus.opcode = c.op;
            bus.zero = c.z;
            #1;
            got = {bus.state, bus.instr_req, bus.ir_write, bus.mem_read, bus.mem_write,
                   bus.reg_write, bus.pc_write, bus.pc_src,
                   (c.st inside {3'd2, 3'd3, 3'd4}) ?
                       {bus.reg2loc, bus.alusrc, bus.mem2reg, bus.move, bus.aluop, bus.signop} : 11'd0,
                   bus.illegal, bus.timeout};
            exp = {c.st, c.s, c.m, c.f};
            total++;
            if (got !== exp)
                $display("FAIL %s cycle %0d: got st=%0d s=%b m=%b f=%b, expected st=%0d s=%b m=%b f=%b",
                         nm, n, got[22:20], got[19:13], got[12:2], got[1:0], c.st, c.s, c.m, c.f);
            else passed++;
            if (bus.pc_write === 1'b1) pulses++;
            n++;
            @(negedge CLK);
        end
    endtask

    task automatic do_reset(input string nm);
        Reset_L = 1'b0;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) begin
                @(posedge CLK);
                #1;
            end else #1;
            total++;
            if ({bus.state, bus.instr_req, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write,
                 bus.pc_write, bus.pc_src, bus.illegal, bus.timeout, bus.aluop, bus.signop,
                 bus.reg2loc, bus.alusrc, bus.mem2reg, bus.move} !== 23'd0)
                $display("FAIL %s reset-%0d: got st=%0d ireq=%b ir=%b pcw=%b rw=%b mw=%b ill=%b to=%b, expected all 0",
                         nm, i, bus.state, bus.instr_req, bus.ir_write, bus.pc_write, bus.reg_write,
                         bus.mem_write, bus.illegal, bus.timeout);
            else passed++;
        end
        @(negedge CLK);
        Reset_L = 1'b1;
    endtask

    task automatic test_reset();
        do_reset("reset");
    endtask

    task automatic test_alu();
        run_instr(11'b10001011000, 1'b0, 0, 0, 1, 1'b0, M_ADD);
        run_instr(11'b11001011000, 1'b0, 0, 0, 1, 1'b0, M_SUB);
        run_instr(11'b10010001000, 1'b0, 1, 0, 1, 1'b0, M_ADD);
        run_instr(11'b11010001000, 1'b0, 0, 0, 1, 1'b0, M_SUB);
        run_instr(11'b10001010000, 1'b0, 0, 0, 1, 1'b0, M_AND);
        run_instr(11'b10101010000, 1'b0, 0, 0, 1, 1'b0, M_ORR);
        run_instr(11'b11010010100, 1'b0, 2, 0, 1, 1'b0, M_MOVZ);
        drain("alu");
    endtask

    task automatic test_mem();
        run_instr(11'b11111000010, 1'b0, 0, 3, 2, 1'b0, M_LDUR);
        run_instr(11'b11111000000, 1'b0, 0, 0, 3, 1'b0, M_STUR);
        run_instr(11'b11111000010, 1'b0, 1, 0, 2, 1'b0, M_LDUR);
        run_instr(11'b11111000000, 1'b0, 0, 2, 3, 1'b0, M_STUR);
        drain("mem");
    endtask

    task automatic test_branch();
        run_instr(11'b10110100101, 1'b1, 0, 0, 0, 1'b1, M_CBZ);
        run_instr(11'b10110100010, 1'b0, 0, 0, 0, 1'b0, M_CBZ);
        run_instr(11'b00010100000, 1'b0, 0, 0, 0, 1'b1, M_B);
        drain("branch");
    endtask

    task automatic test_back_to_back();
        int p0 = pulses;
        run_instr(11'b00010111111, 1'b1, 0, 0, 0, 1'b1, M_B);
        run_instr(11'b11111000000, 1'b0, 1, 1, 3, 1'b0, M_STUR);
        run_instr(11'b11111000010, 1'b0, 0, 0, 2, 1'b0, M_LDUR);
        run_instr(11'b10001011111, 1'b0, 0, 0, 1, 1'b0, M_ADD);
        drain("b2b");
        total++;
        if (pulses - p0 !== 4) $display("FAIL b2b pc_write pulses: got %0d, expected 4", pulses - p0);
        else passed++;
    endtask

    task automatic test_illegal();
        push(1'b1, rop(), rbit(), 3'd0, S_FR, 11'd0, 2'b00);
        push(1'b1, 11'b00000000000, rbit(), 3'd1, 7'd0, 11'd0, 2'b00);
        for (int i = 0; i < 20; i++) push(rbit(), rop(), rbit(), 3'd5, 7'd0, 11'd0, 2'b10);
        drain("illegal");
        do_reset("illegal");
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 4; i++) push(1'b0, rop(), rbit(), 3'd0, S_FW, 11'd0, 2'b00);
        push(1'b0, rop(), rbit(), 3'd0, 7'd0, 11'd0, 2'b00);
        for (int i = 0; i < 3; i++) push(rbit(), rop(), rbit(), 3'd5, 7'd0, 11'd0, 2'b01);
        drain("timeout_fetch");
        do_reset("timeout_fetch");
        run_instr(11'b10001011000, 1'b0, 4, 0, 1, 1'b0, M_ADD);
        drain("ready_at_limit_fetch");
        run_instr(11'b11111000010, 1'b0, 0, 4, 2, 1'b0, M_LDUR);
        drain("ready_at_limit_mem");
        push(1'b1, rop(), rbit(), 3'd0, S_FR, 11'd0, 2'b00);
        push(1'b1, 11'b11111000010, rbit(), 3'd1, 7'd0, 11'd0, 2'b00);
        push(1'b1, rop(), rbit(), 3'd2, 7'd0, M_LDUR, 2'b00);
        for (int i = 0; i < 4; i++) push(1'b0, rop(), rbit(), 3'd3, S_RD, M_LDUR, 2'b00);
        push(1'b0, rop(), rbit(), 3'd3, 7'd0, M_LDUR, 2'b00);
        for (int i = 0; i < 2; i++) push(rbit(), rop(), rbit(), 3'd5, 7'd0, 11'd0, 2'b01);
        drain("timeout_mem");
        do_reset("timeout_mem");
    endtask

    task automatic test_reset_mid();
        push(1'b1, rop(), rbit(), 3'd0, S_FR, 11'd0, 2'b00);
        push(1'b1, 11'b11111000000, rbit(), 3'd1, 7'd0, 11'd0, 2'b00);
        push(1'b1, rop(), rbit(), 3'd2, 7'd0, M_STUR, 2'b00);
        for (int i = 0; i < 2; i++) push(1'b0, rop(), rbit(), 3'd3, S_WR, M_STUR, 2'b00);
        drain("reset_mid");
        total++;
        if (bus.state !== 3'd3 || bus.mem_write !== 1'b1)
            $display("FAIL reset_mid pre-reset: got st=%0d mem_write=%b, expected st=3 mem_write=1",
                     bus.state, bus.mem_write);
        else passed++;
        do_reset("reset_mid");
        run_instr(11'b10001011000, 1'b0, 0, 0, 1, 1'b0, M_ADD);
        drain("restart");
    endtask

    initial begin
        bus.opcode = '0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        #2;
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multi-cycle control unit for the LEGv8 datapath. It decodes the 11-bit opcode once per instruction and sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK through a Moore FSM. A ready handshake lets instruction and data memory take a variable number of cycles, and the block traps on illegal opcodes and memory timeouts. It sits between the instruction register and the datapath muxes and enables.

## Interface
- MAX_WAIT, 15, max cycles a memory request may stay unacknowledged before timeout trap; 0 disables timeout
- ALUOP_W, 4, aluop width; must be ≥4
- SIGNOP_W, 3, signop width; must be ≥3
- CLK  in  1  clock, all state updates on rising edge
- Reset_L  in  1  asynchronous, active-low reset
- opcode  in  11  instruction bits [31:21] from the instruction register
- zero  in  1  ALU zero flag, sampled in EXECUTE
- mem_ready  in  1  memory acknowledge for the current request
- instr_req  out  1  instruction fetch request
- ir_write  out  1  load instruction register
- mem_read / mem_write  out  1 each  data memory strobes
- reg_write  out  1  register file write enable
- pc_write  out  1  PC load enable
- pc_src  out  1  0 = PC+4, 1 = branch target
- reg2loc, alusrc, mem2reg, move  out  1 each  datapath mux selects
- aluop  out  ALUOP_W  ALU operation
- signop  out  SIGNOP_W  sign-extend mode
- state  out  3  current FSM state encoding
- illegal  out  1  sticky, unsupported opcode trapped
- timeout  out  1  sticky, memory handshake timeout trapped

## Operation
- Decode priority, first match wins: LDUR ??111000010, STUR ??111000000, ADDREG ?0?01011???, SUBREG ?1?01011???, ADDIMM ?0?10001???, SUBIMM ?1?10001???, ANDREG ?0001010???, ORRREG ?0101010???, CBZ ?011010????, B ?00101?????, MOVZ 110100101??. Any other opcode is illegal.
- aluop: ADD/LDUR/STUR/ADDIMM 0010, SUB/SUBIMM 0110, AND 0000, ORR 0001, CBZ 0111.
- signop: LDUR/STUR 010, B 001, CBZ 011, ADDIMM/SUBIMM 000, MOVZ 100.
- Mux selects:
  - reg2loc = 1 for STUR and CBZ.
  - alusrc = 1 for LDUR and STUR.
  - mem2reg = 1 for LDUR.
  - move = 1 for MOVZ.
  - Every don't-care field is driven 0. No X ever appears on an output.
- The class and control word are latched at the end of DECODE. The opcode is ignored in later states.
- States: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=5.
- FETCH:
  - instr_req=1.
  - On mem_ready: ir_write=1, go to DECODE.
  - Otherwise stay and increment the wait counter.
- DECODE:
  - Illegal opcode: set illegal, go to TRAP.
  - Otherwise go to EXECUTE.
- EXECUTE, by class:
  - B: pc_write=1, pc_src=1, go to FETCH.
  - CBZ: pc_write=1, pc_src=zero, go to FETCH.
  - LDUR/STUR: go to MEMORY.
  - R-type, immediate and MOVZ: go to WRITEBACK.
- MEMORY:
  - Assert mem_read (LDUR) or mem_write (STUR) until mem_ready.
  - On ready, LDUR goes to WRITEBACK.
  - On ready, STUR asserts pc_write=1, pc_src=0, and goes to FETCH.
- WRITEBACK: reg_write=1, pc_write=1, pc_src=0, go to FETCH.
- TRAP:
  - All strobes are 0; illegal/timeout are held.
  - Only reset exits TRAP.
- Wait counter:
  - Width is clog2(MAX_WAIT+1).
  - Cleared on every state change.
  - In FETCH/MEMORY, if mem_ready is low and the counter equals MAX_WAIT (MAX_WAIT>0): set timeout, go to TRAP. No strobes are issued that cycle.

## Timing
- Reset (asynchronous, Reset_L=0):
  - state=FETCH, counter=0, illegal=0, timeout=0.
  - Latched class = none; all outputs 0 except instr_req.
  - instr_req is 1 in FETCH, but is held at 0 while Reset_L=0.
- Outputs are combinational from state and the latched word. pc_src for CBZ also depends on zero in the same cycle.
- Cycles with zero-wait memory (mem_ready high in the request cycle):
  - B/CBZ: 3.
  - R/I/MOVZ and STUR: 4.
  - LDUR: 5.
- Each memory wait cycle adds 1.
- mem_ready arriving in the same cycle the counter hits MAX_WAIT: ready wins, no timeout.
- mem_ready outside FETCH/MEMORY is ignored.
- Reset mid-instruction aborts it with no pc_write or reg_write on that edge.
- Exactly one pc_write pulse per completed instruction. pc_write never coincides with ir_write.

## Test plan
- ADDREG opcode 10001011000, mem_ready always 1 -> states 0,1,2,4,0. reg_write and pc_write high only in state 4; aluop=0010.
- LDUR 11111000010, data mem_ready delayed 3 cycles -> mem_read high 4 cycles in MEMORY; reg_write with mem2reg=1 in WRITEBACK; total 8 cycles.
- CBZ 10110100xxx with zero=1, then zero=0 -> pc_write in EXECUTE with pc_src=1, then pc_src=0; aluop=0111, signop=011.
- Opcode 00000000000 -> illegal=1 after DECODE, state=5 held 20 cycles, no strobes; Reset_L low returns state=0, illegal=0.
- MAX_WAIT=4, mem_ready stuck low in FETCH -> timeout=1 and state=5 on the 5th cycle. Repeat with ready arriving on the 5th cycle -> no timeout.
- Reset_L pulsed low during MEMORY of STUR -> mem_write drops asynchronously, no pc_write; fetch restarts.
